// File: rtl/cam_capture_rgb332.sv
// Purpose: capture an OV7670 RGB565 byte stream under VSYNC/HREF framing, pack each
//   pixel to RGB332 and write it to a dual-port frame buffer at a linear address.
// Latency: one clk from the second byte of a pixel to its write strobe. There is no
//   backpressure: the camera cannot be stalled, so writes past the frame are dropped.
//
// Ports:
//   clk, rst              camera pixel clock, synchronous active-high reset
//   CAM_vsync, CAM_href   frame sync (high = blanking), line valid
//   CAM_px_data           RGB565 byte stream, high byte first
//   DP_RAM_addr_in/data_in/regW   registered buffer write port, one-clk strobe
//   frame_done            one-clk pulse when vsync rises during capture
//   overflow, byte_err    sticky status, cleared when vsync falls
module cam_capture_rgb332 #(
  parameter int CAM_SCREEN_X = 320,
  parameter int CAM_SCREEN_Y = 240,
  parameter int AW           = 17,
  parameter int DW           = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          DP_RAM_regW,
  output logic          frame_done,
  output logic          overflow,
  output logic          byte_err
);

  localparam logic [1:0] WAIT_VS     = 2'd0;
  localparam logic [1:0] FRAME_START = 2'd1;
  localparam logic [1:0] BYTE1       = 2'd2;
  localparam logic [1:0] BYTE2       = 2'd3;

  // Address PIX_TOTAL belongs to the reader's background pixel; never written.
  localparam logic [AW-1:0] PIX_TOTAL = AW'(CAM_SCREEN_X * CAM_SCREEN_Y);

  logic [1:0]    state;
  logic [AW-1:0] pix_cnt;
  // Only the first byte's R[4:2] and G[5:3] bits survive the RGB332 packing.
  logic [5:0]    byte1_keep;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= WAIT_VS;
      pix_cnt        <= '0;
      byte1_keep     <= '0;
      DP_RAM_addr_in <= '0;
      DP_RAM_data_in <= '0;
      DP_RAM_regW    <= 1'b0;
      frame_done     <= 1'b0;
      overflow       <= 1'b0;
      byte_err       <= 1'b0;
    end else begin
      DP_RAM_regW <= 1'b0;
      frame_done  <= 1'b0;

      case (state)
        // Skip any partial frame until the first full blanking interval is seen.
        WAIT_VS: begin
          if (CAM_vsync) state <= FRAME_START;
        end

        FRAME_START: begin
          if (!CAM_vsync) begin
            pix_cnt  <= '0;
            overflow <= 1'b0;
            byte_err <= 1'b0;
            state    <= BYTE1;
          end
        end

        BYTE1: begin
          if (CAM_vsync) begin
            frame_done <= 1'b1;
            state      <= FRAME_START;
          end else if (CAM_href) begin
            byte1_keep <= {CAM_px_data[7:5], CAM_px_data[2:0]};
            state      <= BYTE2;
          end
        end

        BYTE2: begin
          // vsync wins over href: a pending first byte is simply abandoned.
          if (CAM_vsync) begin
            frame_done <= 1'b1;
            state      <= FRAME_START;
          end else if (CAM_href) begin
            if (pix_cnt < PIX_TOTAL) begin
              DP_RAM_data_in <= DW'({byte1_keep, CAM_px_data[4:3]});
              DP_RAM_addr_in <= pix_cnt;
              DP_RAM_regW    <= 1'b1;
              pix_cnt        <= pix_cnt + AW'(1);
            end else begin
              // Saturate rather than wrap so the start of the frame is not overwritten.
              overflow <= 1'b1;
            end
            state <= BYTE1;
          end else begin
            // Line ended between the two bytes of a pixel.
            byte_err <= 1'b1;
            state    <= BYTE1;
          end
        end

        default: state <= WAIT_VS;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture_rgb332.sv
module tb_cam_capture_rgb332;

  localparam int X  = 4;
  localparam int Y  = 2;
  localparam int NP = X * Y;
  localparam int BX = 40;
  localparam int BY = 30;
  localparam int BN = BX * BY;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small-frame instance
  logic       rst = 1'b1, vs = 1'b0, hr = 1'b0;
  logic [7:0] pd = 8'h00;
  logic [3:0] addr;
  logic [7:0] data;
  logic       regw, fdone, ovf, berr;

  cam_capture_rgb332 #(.CAM_SCREEN_X(X), .CAM_SCREEN_Y(Y), .AW(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .CAM_vsync(vs), .CAM_href(hr), .CAM_px_data(pd),
    .DP_RAM_addr_in(addr), .DP_RAM_data_in(data), .DP_RAM_regW(regw),
    .frame_done(fdone), .overflow(ovf), .byte_err(berr)
  );

  // Larger-frame instance for a complete frame run
  logic        rst2 = 1'b1, vs2 = 1'b0, hr2 = 1'b0;
  logic [7:0]  pd2 = 8'h00;
  logic [10:0] addr2;
  logic [7:0]  data2;
  logic        regw2, fdone2, ovf2, berr2;

  cam_capture_rgb332 #(.CAM_SCREEN_X(BX), .CAM_SCREEN_Y(BY), .AW(11), .DW(8)) dut_big (
    .clk(clk), .rst(rst2), .CAM_vsync(vs2), .CAM_href(hr2), .CAM_px_data(pd2),
    .DP_RAM_addr_in(addr2), .DP_RAM_data_in(data2), .DP_RAM_regW(regw2),
    .frame_done(fdone2), .overflow(ovf2), .byte_err(berr2)
  );

  int checks = 0;
  int passed = 0;

  // Reference: RGB565 (hi, lo) -> RGB332 by arithmetic on the color fields.
  function automatic int pack332(input int b1, input int b2);
    int r5, g6, b5;
    r5 = b1 / 8;
    g6 = (b1 % 8) * 8 + b2 / 32;
    b5 = b2 % 32;
    return (r5 / 4) * 32 + (g6 / 8) * 4 + (b5 / 8);
  endfunction

  // Monitors (sampled on the falling edge)
  int   wr_q[$];
  int   exp_q[$];
  int   b2b = 0;
  int   fd_cnt = 0;
  logic prev_w = 1'b0;
  int   wr2_cnt = 0, mism2 = 0, fd2_cnt = 0, last2 = -1;

  always @(negedge clk) begin
    if (regw) wr_q.push_back(int'(addr) * 256 + int'(data));
    if (regw && prev_w) b2b++;
    prev_w = regw;
    if (fdone) fd_cnt++;
    if (regw2) begin
      if (int'(addr2) != wr2_cnt || int'(data2) != pack332(wr2_cnt / 256, wr2_cnt % 256)) mism2++;
      last2 = int'(addr2);
      wr2_cnt++;
    end
    if (fdone2) fd2_cnt++;
  end

  // Model of frame-level counting
  int   mcount = 0;
  logic m_ovf = 1'b0;
  logic m_berr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    hr = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    hr = 1'b1;
    pd = b;
    tick();
  endtask

  task automatic pixel(input logic [7:0] b1, input logic [7:0] b2);
    send(b1);
    send(b2);
    if (mcount < NP) begin
      exp_q.push_back(mcount * 256 + pack332(int'(b1), int'(b2)));
      mcount++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic vs_high();
    hr = 1'b0;
    vs = 1'b1;
    repeat (3) tick();
  endtask

  task automatic vs_low();
    vs = 1'b0;
    repeat (2) tick();
    mcount = 0;
    m_ovf  = 1'b0;
    m_berr = 1'b0;
  endtask

  task automatic frame_start();
    vs_high();
    vs_low();
  endtask

  task automatic cmp_writes(input string tag);
    int n;
    chk({tag, "_count"}, wr_q.size(), exp_q.size());
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_write"}, wr_q[i], exp_q[i]);
    wr_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] r1, r2;

    // 1. Reset with href toggling, then first pixel
    for (int i = 0; i < 3; i++) begin
      hr = i[0];
      pd = 8'hA5;
      tick();
    end
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    chk("rst_regw", regw, 0);
    chk("rst_fdone", fdone, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_berr", berr, 0);
    rst = 1'b0;
    rst2 = 1'b0;
    frame_start();
    pixel(8'hF8, 8'h1F);
    chk("t1_regw", regw, 1);
    chk("t1_addr", addr, 0);
    chk("t1_data", data, 8'hE3);
    idle(1);
    chk("t1_regw_one", regw, 0);
    chk("t1_addr_hold", addr, 0);
    chk("t1_data_hold", data, 8'hE3);
    idle(2);
    cmp_writes("t1");

    // 2. Full frame of 07,E0, then frame end
    frame_start();
    fd_cnt = 0;
    b2b = 0;
    for (int l = 0; l < Y; l++) begin
      for (int p = 0; p < X; p++) pixel(8'h07, 8'hE0);
      idle(3);
    end
    cmp_writes("t2");
    chk("t2_no_b2b", b2b, 0);
    vs_high();
    chk("t2_fdone_once", fd_cnt, 1);
    chk("t2_ovf", ovf, m_ovf);

    // 3. Odd byte at end of line
    vs_low();
    pixel(8'hF8, 8'h1F);
    send(8'h07);
    idle(2);
    m_berr = 1'b1;
    chk("t3_berr", berr, m_berr);
    r1 = 8'($urandom);
    r2 = 8'($urandom);
    pixel(r1, r2);
    idle(2);
    cmp_writes("t3");

    // 4. Overflow; byte_err from the previous frame survives blanking
    vs_high();
    chk("t4_berr_in_blank", berr, 1);
    vs_low();
    chk("t4_berr_cleared", berr, 0);
    for (int p = 0; p < 10; p++) begin
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      pixel(r1, r2);
      if (p == 7) chk("t4_ovf_before", ovf, 0);
      if (p == 8) chk("t4_ovf_after9", ovf, m_ovf);
      if (p == 4) idle(2);
    end
    idle(2);
    cmp_writes("t4");
    vs_high();
    chk("t4_ovf_in_blank", ovf, 1);
    vs_low();
    chk("t4_ovf_cleared", ovf, 0);

    // 5a. vsync while in BYTE2 with href high
    pixel(8'h12, 8'h34);
    send(8'hF8);
    vs = 1'b1;
    hr = 1'b1;
    pd = 8'h1F;
    tick();
    chk("t5_vs_regw", regw, 0);
    chk("t5_vs_fdone", fdone, 1);
    tick();
    chk("t5_fdone_pulse", fdone, 0);
    hr = 1'b0;
    tick();
    cmp_writes("t5a");

    // 5b. Reset between the two bytes of a pixel
    vs_low();
    send(8'hF8);
    rst = 1'b1;
    pd = 8'h1F;
    tick();
    chk("t5_rst_regw", regw, 0);
    rst = 1'b0;
    idle(1);
    pixel(8'hF8, 8'h1F);
    pixel(8'h07, 8'hE0);
    idle(2);
    exp_q.delete();
    chk("t5_no_capture_before_vs", wr_q.size(), 0);
    frame_start();
    r1 = 8'($urandom);
    r2 = 8'($urandom);
    pixel(r1, r2);
    idle(2);
    cmp_writes("t5b");

    // 6. Complete frame of incrementing RGB565 on the larger instance
    vs2 = 1'b1;
    repeat (3) tick();
    vs2 = 1'b0;
    repeat (2) tick();
    for (int l = 0; l < BY; l++) begin
      for (int p = 0; p < BX; p++) begin
        hr2 = 1'b1;
        pd2 = 8'((l * BX + p) / 256);
        tick();
        pd2 = 8'((l * BX + p) % 256);
        tick();
      end
      hr2 = 1'b0;
      repeat (2) tick();
    end
    vs2 = 1'b1;
    repeat (3) tick();
    chk("t6_writes", wr2_cnt, BN);
    chk("t6_last_addr", last2, BN - 1);
    chk("t6_data_addr", mism2, 0);
    chk("t6_fdone_once", fd2_cnt, 1);
    chk("t6_ovf", ovf2, 0);
    chk("t6_berr", berr2, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cam_capture_rgb332.md
# cam_capture_rgb332

Camera-side capture block for the OV7670 path. Samples the camera's 8-bit RGB565 byte stream under VSYNC/HREF framing and packs each pixel to RGB332. Writes each pixel into the dual-port frame buffer's write port as a one-cycle write strobe with a linear address. The VGA side reads this buffer back at 25 MHz; this block is the writer for that reader.

## Interface
- CAM_SCREEN_X, 320, captured pixels per line.
- CAM_SCREEN_Y, 240, captured lines per frame.
- AW, 17, buffer address width; must satisfy 2^AW > CAM_SCREEN_X*CAM_SCREEN_Y.
- DW, 8, buffer data width (RGB332).
- clk  in  1  camera pixel clock (PCLK); all logic on rising edge.
- rst  in  1  reset; synchronous to clk and active-high.
- CAM_vsync  in  1  frame sync; high = vertical blanking.
- CAM_href  in  1  line valid; high = bytes on CAM_px_data are pixel bytes.
- CAM_px_data  in  8  RGB565 byte stream, high byte first.
- DP_RAM_addr_in  out  AW  write address, registered.
- DP_RAM_data_in  out  DW  RGB332 write data, registered.
- DP_RAM_regW  out  1  write strobe, one clk per pixel.
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- overflow  out  1  sticky: frame delivered more than X*Y pixels.
- byte_err  out  1  sticky: a line ended on an odd byte.

## Operation
- States: WAIT_VS, FRAME_START, BYTE1, BYTE2.
- Reset: state = WAIT_VS. All outputs are 0: addr, data, regW, frame_done, overflow, byte_err.
- WAIT_VS: wait for CAM_vsync=1, then go to FRAME_START. This discards any partial frame present at power-up.
- FRAME_START: hold while vsync=1. On the first cycle with vsync=0:
  - pixel counter <= 0, overflow <= 0, byte_err <= 0;
  - go to BYTE1.
- BYTE1:
  - href=1: latch byte1 <= CAM_px_data and go to BYTE2.
  - href=0: stay.
- BYTE2 with href=1:
  - DP_RAM_data_in <= {byte1[7:5], byte1[2:0], CAM_px_data[4:3]}, i.e. R5→R3, G6→G3 using G[5:3], B5→B2.
  - If counter < X*Y: DP_RAM_addr_in <= counter, regW <= 1, counter <= counter+1.
  - Otherwise: regW stays 0, overflow <= 1, counter holds (saturates).
  - Go to BYTE1.
- BYTE2 with href=0: the line ended mid-pixel. Drop byte1, set byte_err <= 1, go to BYTE1, and do not advance the counter.
- vsync=1 while in BYTE1 or BYTE2: frame_done <= 1 for one cycle, go to FRAME_START, and discard any pending byte1. This takes priority over href in the same cycle.
- Address is linear: addr = line*CAM_SCREEN_X + column. This matches the reader's row-major layout.
  - Address X*Y is reserved for the reader's background pixel and is never written.
- Counter width is AW. No wrap-around is permitted: writes beyond X*Y-1 are suppressed, not wrapped.
- Pixels per line are not checked. Lines longer than X shift later lines, but total writes are still capped at X*Y.

## Timing
- Pixel write latency: byte2 sampled at edge N, so regW=1 with valid addr/data during cycle N+1 (exactly one cycle).
- regW is high for at most 1 of every 2 clks, and never on consecutive cycles.
- addr/data hold their last value when regW=0.
- frame_done is high in the cycle after vsync is first sampled high in a capture state.
- overflow/byte_err are cleared only on the vsync falling transition (FRAME_START → BYTE1) or by rst. Both therefore remain readable through the vertical blanking interval.
- rst mid-line: next edge returns to WAIT_VS with regW=0. No write is issued for a half-captured pixel.

## Test plan
Use CAM_SCREEN_X=4, CAM_SCREEN_Y=2, AW=4 unless noted.
1. Reset and start: hold rst 3 cycles with href toggling → all outputs 0. Then vsync 1→0 followed by href bytes F8,1F → regW=1 for one cycle, addr=0, data=E3.
2. Full frame: 2 lines of 4 pixels using bytes 07,E0 → 8 writes, addr 0..7, data=1C, regW never on back-to-back cycles. Then vsync=1 → frame_done pulses once.
3. Odd byte: line of 3 bytes (F8,1F,07) then href=0 → exactly one write (addr 0, E3) and byte_err=1. Next line's first pixel goes to addr 1.
4. Overflow: 10 pixels in one frame → writes only to addr 0..7, overflow=1 after the 9th pixel, counter stays 8. Next vsync fall clears overflow.
5. Mid-frame vsync and reset: vsync=1 with href=1 in BYTE2 → no write and frame_done=1. Separately, rst asserted between byte1 and byte2 → no write, and the block waits for a fresh vsync before capturing again.
6. Default size: 320×240 frame of incrementing RGB565 → 76800 writes, last addr 76799, frame_done once, overflow=0.
